// File: rtl/sp_ram_bridge_if.sv
// Core-bus and sp_ram signal bundle for sp_ram_bridge.
// The slave modport is the bridge; the master modport is the core/RAM side.
interface sp_ram_bridge_if #(
  parameter int unsigned AW = 12
) ();
  logic          i_bus_en;
  logic          i_wr_rd;
  logic [31:0]   i_wr_data;
  logic [31:0]   i_addr;
  logic [1:0]    i_size;
  logic          o_ack;
  logic [31:0]   o_rd_data;
  logic          o_err;
  logic          o_cs;
  logic          o_wr_en;
  logic [3:0]    o_b_en;
  logic [31:0]   o_wr_data;
  logic [AW-1:0] o_addr;
  logic [31:0]   i_rd_data;

  modport slave (
    input  i_bus_en, i_wr_rd, i_wr_data, i_addr, i_size, i_rd_data,
    output o_ack, o_rd_data, o_err, o_cs, o_wr_en, o_b_en, o_wr_data, o_addr
  );

  modport master (
    output i_bus_en, i_wr_rd, i_wr_data, i_addr, i_size, i_rd_data,
    input  o_ack, o_rd_data, o_err, o_cs, o_wr_en, o_b_en, o_wr_data, o_addr
  );
endinterface

// File: rtl/sp_ram_bridge.sv
// Core bus to sp_ram bridge: one request at a time, lane steering, single-cycle ack.
// Define SP_RAM_BRIDGE_ERR_EN to flag misaligned, bad-size and out-of-range accesses.
module sp_ram_bridge #(
  parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
  parameter int unsigned MEM_DEPTH = 4096,
  parameter int unsigned RD_LAT    = 2
) (
  input  logic           i_clk,
  input  logic           i_rst,
  sp_ram_bridge_if.slave bus
);
  localparam int unsigned AW = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StAck} state_e;

  state_e        state_q, state_d;
  logic          wr_rd_q, wr_rd_d;
  logic [1:0]    lane_q, lane_d;
  logic [1:0]    size_q, size_d;
  logic          err_q, err_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          cs_q, cs_d;
  logic          wr_en_q, wr_en_d;
  logic [3:0]    b_en_q, b_en_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic          ack_q, ack_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          oerr_q, oerr_d;
  logic          req_err;
  logic [31:0]   rd_lanes;

`ifdef SP_RAM_BRIDGE_ERR_EN
  always_comb begin
    req_err = 1'b0;
    unique case (bus.i_size)
      2'b00:   req_err = 1'b0;
      2'b01:   req_err = bus.i_addr[0];
      2'b10:   req_err = |bus.i_addr[1:0];
      default: req_err = 1'b1;
    endcase
    if ((bus.i_addr - ADDR_BASE) >= 32'(4 * MEM_DEPTH)) req_err = 1'b1;
  end
`else
  assign req_err = 1'b0;
`endif

  always_comb begin
    case (size_q)
      2'b00:   rd_lanes = (bus.i_rd_data >> {lane_q, 3'b000}) & 32'h0000_00ff;
      2'b01:   rd_lanes = (bus.i_rd_data >> {lane_q[1], 4'b0000}) & 32'h0000_ffff;
      default: rd_lanes = bus.i_rd_data;
    endcase
  end

  always_comb begin
    state_d = state_q;
    wr_rd_d = wr_rd_q;
    lane_d  = lane_q;
    size_d  = size_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    // RAM strobes and bus responses are single-cycle pulses unless set below
    cs_d    = 1'b0;
    wr_en_d = 1'b0;
    b_en_d  = '0;
    wdata_d = '0;
    waddr_d = '0;
    ack_d   = 1'b0;
    rdata_d = '0;
    oerr_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.i_bus_en) begin
          state_d = StIssue;
          wr_rd_d = bus.i_wr_rd;
          lane_d  = bus.i_addr[1:0];
          size_d  = bus.i_size;
          err_d   = req_err;
          cs_d    = ~req_err;
          wr_en_d = bus.i_wr_rd & ~req_err;
          waddr_d = AW'((bus.i_addr - ADDR_BASE) >> 2);
          case (bus.i_size)
            2'b00: begin
              b_en_d  = 4'b0001 << bus.i_addr[1:0];
              wdata_d = {4{bus.i_wr_data[7:0]}};
            end
            2'b01: begin
              b_en_d  = 4'b0011 << {bus.i_addr[1], 1'b0};
              wdata_d = {2{bus.i_wr_data[15:0]}};
            end
            default: begin
              b_en_d  = 4'b1111;
              wdata_d = bus.i_wr_data;
            end
          endcase
        end
      end
      StIssue: begin
        if (err_q || wr_rd_q) begin
          state_d = StAck;
          ack_d   = 1'b1;
          oerr_d  = err_q;
        end else begin
          state_d = StWait;
          cnt_d   = 2'(RD_LAT - 1);
        end
      end
      StWait: begin
        if (cnt_q == 2'd0) begin
          state_d = StAck;
          ack_d   = 1'b1;
          rdata_d = rd_lanes;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
      wr_rd_q <= 1'b0;
      lane_q  <= '0;
      size_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      cs_q    <= 1'b0;
      wr_en_q <= 1'b0;
      b_en_q  <= '0;
      wdata_q <= '0;
      waddr_q <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      oerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_rd_q <= wr_rd_d;
      lane_q  <= lane_d;
      size_q  <= size_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      cs_q    <= cs_d;
      wr_en_q <= wr_en_d;
      b_en_q  <= b_en_d;
      wdata_q <= wdata_d;
      waddr_q <= waddr_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      oerr_q  <= oerr_d;
    end
  end

  assign bus.o_cs      = cs_q;
  assign bus.o_wr_en   = wr_en_q;
  assign bus.o_b_en    = b_en_q;
  assign bus.o_wr_data = wdata_q;
  assign bus.o_addr    = waddr_q;
  assign bus.o_ack     = ack_q;
  assign bus.o_rd_data = rdata_q;
  assign bus.o_err     = oerr_q;
endmodule

// File: tb/tb_sp_ram_bridge.sv
// Bench for sp_ram_bridge: directed vector table, reset/back-to-back sequences,
// and random traffic checked against a byte-addressed memory model.
module tb_sp_ram_bridge;
  localparam logic [31:0] BASE      = 32'h8000_0000;
  localparam int unsigned MEM_DEPTH = 4096;
  localparam int unsigned RD_LAT    = 2;
  localparam int unsigned AW        = 12;
  localparam int          MEM_BYTES = 4 * MEM_DEPTH;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sp_ram_bridge_if #(.AW(AW)) bus ();

  sp_ram_bridge #(
    .ADDR_BASE(BASE),
    .MEM_DEPTH(MEM_DEPTH),
    .RD_LAT   (RD_LAT)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int cs_times[$];
  int ack_times[$];
  logic prev_cs = 1'b0;
  logic prev_ack = 1'b0;

  // Behavioural sp_ram with RD_LAT edges from chip-select to data
  logic [31:0] ram  [MEM_DEPTH] = '{default: '0};
  logic [31:0] pipe [RD_LAT]    = '{default: '0};
  logic [31:0] merged;
  assign bus.i_rd_data = pipe[RD_LAT-1];

  always_comb begin
    merged = ram[bus.o_addr];
    for (int b = 0; b < 4; b++)
      if (bus.o_b_en[b]) merged[8*b +: 8] = bus.o_wr_data[8*b +: 8];
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.o_cs) begin
      if (bus.o_wr_en) ram[bus.o_addr] <= merged;
      else pipe[0] <= ram[bus.o_addr];
    end
    for (int k = 1; k < RD_LAT; k++) pipe[k] <= pipe[k-1];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.o_cs) begin
      cs_times.push_back(cyc);
      chk("cs_single_cycle", {31'b0, prev_cs}, 32'd0);
    end
    if (bus.o_ack) begin
      ack_times.push_back(cyc);
      chk("ack_single_cycle", {31'b0, prev_ack}, 32'd0);
    end
    prev_cs  <= bus.o_cs;
    prev_ack <= bus.o_ack;
  end

  // Reference model: flat byte memory, offset modulo RAM size
  logic [7:0] ref_mem [MEM_BYTES] = '{default: '0};

  function automatic int boff(input logic [31:0] a);
    logic [31:0] o;
    o = a - BASE;
    return int'(o % 32'(MEM_BYTES));
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    case (sz)
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic int start_byte(input logic [31:0] a, input logic [1:0] sz);
    int s;
    s = boff(a);
    return s - (s % nbytes(sz));
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    int s;
    s = start_byte(a, sz);
    for (int i = 0; i < nbytes(sz); i++) ref_mem[s+i] = d[8*i +: 8];
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic [1:0] sz);
    logic [31:0] r;
    int s;
    r = '0;
    s = start_byte(a, sz);
    for (int i = 0; i < nbytes(sz); i++) r[8*i +: 8] = ref_mem[s+i];
    return r;
  endfunction

  function automatic logic [3:0] model_ben(input logic [31:0] a, input logic [1:0] sz);
    logic [3:0] m;
    int s;
    m = '0;
    s = start_byte(a, sz);
    for (int i = 0; i < nbytes(sz); i++) m[(s+i)%4] = 1'b1;
    return m;
  endfunction

  // Results of the last transaction
  int            r_ack, r_cs;
  logic [31:0]   r_rd, r_wd;
  logic          r_err, r_wen;
  logic [3:0]    r_ben;
  logic [AW-1:0] r_addr;

  // Called at posedge+1 of cycle 0; returns at posedge+1 of the cycle after ACK
  task automatic txn(input logic wr, input logic [31:0] a, input logic [1:0] sz,
                     input logic [31:0] d, input logic drop);
    r_ack = -1; r_cs = -1; r_rd = '0; r_err = 1'b0;
    r_ben = '0; r_wd = '0; r_addr = '0; r_wen = 1'b0;
    bus.i_bus_en = 1'b1; bus.i_wr_rd = wr; bus.i_addr = a; bus.i_size = sz;
    bus.i_wr_data = d;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.o_cs && r_cs < 0) begin
        r_cs = c; r_ben = bus.o_b_en; r_wd = bus.o_wr_data;
        r_addr = bus.o_addr; r_wen = bus.o_wr_en;
      end
      if (bus.o_ack) begin
        r_ack = c; r_rd = bus.o_rd_data; r_err = bus.o_err;
      end
      @(posedge clk); #1;
      if (drop) bus.i_bus_en = 1'b0;
      if (r_ack >= 0) break;
    end
    bus.i_bus_en = 1'b0;
    if (r_ack < 0) begin
      checks++; errors++;
      $display("FAIL ack_timeout: no ack within 20 cycles, required one");
    end
  endtask

  task automatic chk_outputs_zero(input string name);
    chk({name, "_ctl"}, 32'({bus.o_ack, bus.o_err, bus.o_cs, bus.o_wr_en, bus.o_b_en,
                             bus.o_addr}), 32'd0);
    chk({name, "_data"}, bus.o_wr_data | bus.o_rd_data, 32'd0);
  endtask

  typedef struct {
    logic          wr;
    logic [31:0]   addr;
    logic [1:0]    size;
    logic [31:0]   wdata;
    logic [3:0]    exp_ben;
    logic [31:0]   exp_wd;
    logic [AW-1:0] exp_addr;
    logic [31:0]   exp_rd;
    int            exp_ack;
  } vec_t;

  vec_t vec[$];
  int   c0, a0;
  logic          rw;
  logic [1:0]    rsz;
  logic [31:0]   roff, raddr, rdat;

  initial begin
    vec.push_back('{1'b1, 32'h8000_0010, 2'b10, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 12'd4, 32'h0, 2});
    vec.push_back('{1'b0, 32'h8000_0010, 2'b10, 32'h0, 4'b1111, 32'h0, 12'd4, 32'hDEAD_BEEF, 4});
    vec.push_back('{1'b1, 32'h8000_0013, 2'b00, 32'hA5, 4'b1000, 32'hA5A5_A5A5, 12'd4, 32'h0, 2});
    vec.push_back('{1'b0, 32'h8000_0010, 2'b10, 32'h0, 4'b1111, 32'h0, 12'd4, 32'hA5AD_BEEF, 4});
    vec.push_back('{1'b0, 32'h8000_0012, 2'b01, 32'h0, 4'b1100, 32'h0, 12'd4, 32'h0000_A5AD, 4});
    vec.push_back('{1'b0, 32'h8000_0011, 2'b00, 32'h0, 4'b0010, 32'h0, 12'd4, 32'h0000_00BE, 4});
    vec.push_back('{1'b1, 32'h8000_0022, 2'b01, 32'h1234, 4'b1100, 32'h1234_1234, 12'd8, 32'h0, 2});
    vec.push_back('{1'b0, 32'h8000_0020, 2'b10, 32'h0, 4'b1111, 32'h0, 12'd8, 32'h1234_0000, 4});
`ifndef SP_RAM_BRIDGE_ERR_EN
    vec.push_back('{1'b0, 32'h8000_4000, 2'b10, 32'h0, 4'b1111, 32'h0, 12'd0, 32'h0, 4});
`endif

    bus.i_bus_en = 1'b0; bus.i_wr_rd = 1'b0; bus.i_wr_data = '0;
    bus.i_addr = '0; bus.i_size = '0;
    #1 rst = 1'b1;
    #2 chk_outputs_zero("reset_state");
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    foreach (vec[i]) begin
      txn(vec[i].wr, vec[i].addr, vec[i].size, vec[i].wdata, 1'b0);
      if (vec[i].wr) model_write(vec[i].addr, vec[i].size, vec[i].wdata);
      chk($sformatf("v%0d_cs_cycle", i), 32'(r_cs), 32'd1);
      chk($sformatf("v%0d_ack_cycle", i), 32'(r_ack), 32'(vec[i].exp_ack));
      chk($sformatf("v%0d_b_en", i), 32'(r_ben), 32'(vec[i].exp_ben));
      chk($sformatf("v%0d_wr_data", i), r_wd, vec[i].exp_wd);
      chk($sformatf("v%0d_addr", i), 32'(r_addr), 32'(vec[i].exp_addr));
      chk($sformatf("v%0d_wr_en", i), 32'(r_wen), 32'(vec[i].wr));
      chk($sformatf("v%0d_err", i), 32'(r_err), 32'd0);
      if (!vec[i].wr) chk($sformatf("v%0d_rd_data", i), r_rd, vec[i].exp_rd);
    end

    // Request dropped after cycle 0 still completes
    txn(1'b0, 32'h8000_0010, 2'b10, 32'h0, 1'b1);
    chk("drop_ack_cycle", 32'(r_ack), 32'd4);
    chk("drop_rd_data", r_rd, 32'hA5AD_BEEF);

    // Reset while o_cs is high in ISSUE
    a0 = ack_times.size(); c0 = cs_times.size();
    bus.i_bus_en = 1'b1; bus.i_wr_rd = 1'b0; bus.i_addr = 32'h8000_0010; bus.i_size = 2'b10;
    @(posedge clk); #1;
    chk("issue_cs_high", 32'(bus.o_cs), 32'd1);
    #2 rst = 1'b1;
    #1 chk_outputs_zero("rst_issue");
    bus.i_bus_en = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    repeat (8) @(posedge clk); #1;
    chk("rst_issue_no_ack", 32'(ack_times.size() - a0), 32'd0);
    chk("rst_issue_no_cs", 32'(cs_times.size() - c0), 32'd0);

    // Reset while waiting on read data
    a0 = ack_times.size();
    bus.i_bus_en = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1 chk_outputs_zero("rst_wait");
    bus.i_bus_en = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    repeat (8) @(posedge clk); #1;
    chk("rst_wait_no_ack", 32'(ack_times.size() - a0), 32'd0);
    txn(1'b0, 32'h8000_0010, 2'b10, 32'h0, 1'b0);
    chk("post_rst_rd_data", r_rd, 32'hA5AD_BEEF);

    // Back-to-back writes
    c0 = cs_times.size(); a0 = ack_times.size();
    txn(1'b1, 32'h8000_0030, 2'b10, 32'h1111_1111, 1'b0);
    model_write(32'h8000_0030, 2'b10, 32'h1111_1111);
    txn(1'b1, 32'h8000_0034, 2'b10, 32'h2222_2222, 1'b0);
    model_write(32'h8000_0034, 2'b10, 32'h2222_2222);
    repeat (4) @(posedge clk); #1;
    chk("b2b_cs_count", 32'(cs_times.size() - c0), 32'd2);
    chk("b2b_ack_count", 32'(ack_times.size() - a0), 32'd2);
    if (cs_times.size() - c0 >= 2)
      chk("b2b_cs_gap", 32'(cs_times[c0+1] - cs_times[c0]), 32'd3);
    if (ack_times.size() - a0 >= 2)
      chk("b2b_ack_gap", 32'(ack_times[a0+1] - ack_times[a0]), 32'd3);

`ifdef SP_RAM_BRIDGE_ERR_EN
    txn(1'b0, 32'h8000_0002, 2'b10, 32'h0, 1'b0);
    chk("err_misal_word", 32'(r_err), 32'd1);
    chk("err_misal_ack_cycle", 32'(r_ack), 32'd2);
    chk("err_misal_no_cs", 32'(r_cs), 32'hFFFF_FFFF);
    chk("err_misal_rd_data", r_rd, 32'd0);
    txn(1'b0, 32'h8000_4000, 2'b10, 32'h0, 1'b0);
    chk("err_range", 32'(r_err), 32'd1);
    txn(1'b1, 32'h8000_0011, 2'b01, 32'hFFFF, 1'b0);
    chk("err_misal_half_wr", 32'(r_err), 32'd1);
    chk("err_misal_half_no_cs", 32'(r_cs), 32'hFFFF_FFFF);
`endif

    // Random traffic against the byte model
    for (int n = 0; n < 300; n++) begin
      rw   = 1'($urandom_range(0, 1));
      rdat = $urandom;
`ifdef SP_RAM_BRIDGE_ERR_EN
      rsz  = 2'($urandom_range(0, 2));
      roff = 32'($urandom_range(0, 255));
      roff = roff & ~32'(nbytes(rsz) - 1);
`else
      rsz  = 2'($urandom_range(0, 3));
      roff = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) roff = roff + 32'h4000 * 32'($urandom_range(1, 3));
`endif
      raddr = BASE + roff;
      txn(rw, raddr, rsz, rdat, 1'b0);
      chk("rnd_ack_cycle", 32'(r_ack), rw ? 32'd2 : 32'd4);
      chk("rnd_b_en", 32'(r_ben), 32'(model_ben(raddr, rsz)));
      chk("rnd_addr", 32'(r_addr), 32'(boff(raddr) / 4));
      if (rw) model_write(raddr, rsz, rdat);
      else chk("rnd_rd_data", r_rd, model_read(raddr, rsz));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
